vga_console: RTL and testbench

VGA_CONSOLE -- requirements
Module: vga_console

---
 rtl/vga_console.sv | 175 +++++++++++++++++
 tb/tb_vga_console.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_console.sv
// Text console writer: turns a byte stream into VRAM cell writes and tracks the cursor.
// Char write lands 1 cycle after accept; in_ready drops for the whole PUT/CLRLINE/CLRALL sequence.
module vga_console #(
    parameter int COLS = 40,
    parameter int ROWS = 30,
    parameter int AW   = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic [7:0]    attr,
    output logic [AW-1:0] vram_waddr,
    output logic [15:0]   vram_wdata,
    output logic          vram_we,
    output logic [5:0]    cur_col,
    output logic [4:0]    cur_row,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, PUT, CLRLINE, CLRALL} state_t;

    localparam logic [AW-1:0] LINE_A   = AW'(COLS);
    localparam logic [AW:0]   LINE_N   = (AW+1)'(COLS);
    localparam logic [AW:0]   TOTAL_N  = (AW+1)'(COLS * ROWS);
    localparam logic [AW:0]   ONE      = (AW+1)'(1);
    localparam logic [5:0]    LAST_COL = 6'(COLS - 1);
    localparam logic [4:0]    LAST_ROW = 5'(ROWS - 1);
    localparam logic [7:0]    SPACE    = 8'h20;

    state_t          state_q, state_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [7:0]      attr_q, attr_d, clr_attr;
    logic            init_q, init_d;
    logic            we_d, ready_d, busy_d;
    logic [AW-1:0]   waddr_d;
    logic [15:0]     wdata_d;
    logic [5:0]      col_d;
    logic [4:0]      row_d, row_inc;
    logic [AW-1:0]   base, base_inc;
    logic            acc, printable;

    assign acc       = in_valid && in_ready;
    assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign row_inc   = (cur_row == LAST_ROW) ? 5'd0 : cur_row + 5'd1;
    assign base      = AW'(cur_row) * LINE_A;
    assign base_inc  = AW'(row_inc) * LINE_A;
    // The post-reset clear takes its attribute live on its first cycle, then from attr_q.
    assign clr_attr  = init_q ? attr : attr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CLRALL;
            cnt_q      <= '0;
            attr_q     <= '0;
            init_q     <= 1'b1;
            vram_we    <= 1'b0;
            vram_waddr <= '0;
            vram_wdata <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            cur_col    <= '0;
            cur_row    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            attr_q     <= attr_d;
            init_q     <= init_d;
            vram_we    <= we_d;
            vram_waddr <= waddr_d;
            vram_wdata <= wdata_d;
            in_ready   <= ready_d;
            busy       <= busy_d;
            cur_col    <= col_d;
            cur_row    <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (printable)               state_d = PUT;
                    else if (in_data == 8'h0A)   state_d = CLRLINE;
                    else if (in_data == 8'h0C)   state_d = CLRALL;
                end
            end
            // Cursor already advanced at accept; column 0 here means the line wrapped.
            PUT:     state_d = (cur_col == 6'd0) ? CLRLINE : IDLE;
            CLRLINE: if (cnt_q >= LINE_N)  state_d = IDLE;
            CLRALL:  if (cnt_q >= TOTAL_N) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        we_d    = 1'b0;
        waddr_d = vram_waddr;
        wdata_d = vram_wdata;
        cnt_d   = cnt_q;
        attr_d  = attr_q;
        init_d  = init_q;
        col_d   = cur_col;
        row_d   = cur_row;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    attr_d = attr;
                    if (printable) begin
                        we_d    = 1'b1;
                        waddr_d = base + AW'(cur_col);
                        wdata_d = {attr, in_data};
                        if (cur_col == LAST_COL) begin
                            col_d = '0;
                            row_d = row_inc;
                        end else begin
                            col_d = cur_col + 6'd1;
                        end
                    end else if (in_data == 8'h0A) begin
                        col_d   = '0;
                        row_d   = row_inc;
                        we_d    = 1'b1;
                        waddr_d = base_inc;
                        wdata_d = {attr, SPACE};
                        cnt_d   = ONE;
                    end else if (in_data == 8'h0D) begin
                        col_d = '0;
                    end else if (in_data == 8'h08) begin
                        if (cur_col != 6'd0) col_d = cur_col - 6'd1;
                    end else if (in_data == 8'h0C) begin
                        we_d    = 1'b1;
                        waddr_d = '0;
                        wdata_d = {attr, SPACE};
                        cnt_d   = ONE;
                    end
                end
            end
            PUT: begin
                if (cur_col == 6'd0) begin
                    we_d    = 1'b1;
                    waddr_d = base;
                    wdata_d = {attr_q, SPACE};
                    cnt_d   = ONE;
                end
            end
            CLRLINE: begin
                if (cnt_q < LINE_N) begin
                    we_d    = 1'b1;
                    waddr_d = base + cnt_q[AW-1:0];
                    wdata_d = {attr_q, SPACE};
                    cnt_d   = cnt_q + ONE;
                end
            end
            CLRALL: begin
                init_d = 1'b0;
                attr_d = clr_attr;
                if (cnt_q < TOTAL_N) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q[AW-1:0];
                    wdata_d = {clr_attr, SPACE};
                    cnt_d   = cnt_q + ONE;
                end else begin
                    col_d = '0;
                    row_d = '0;
                end
            end
            default: ;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = !ready_d;
    end

endmodule

// File: tb/tb_vga_console.sv
// Directed bench for vga_console: logs every VRAM strobe and compares against hand-computed cells and cursor positions.
module tb_vga_console;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [7:0]  attr = 8'h07;
    logic [10:0] vram_waddr;
    logic [15:0] vram_wdata;
    logic        vram_we;
    logic [5:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;

    int checks = 0;
    int failures = 0;
    logic [31:0] log_q[$];

    vga_console #(.COLS(40), .ROWS(30), .AW(11)) dut (
        .clk(clk), .reset(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .attr(attr),
        .vram_waddr(vram_waddr), .vram_wdata(vram_wdata), .vram_we(vram_we),
        .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && vram_we) log_q.push_back({5'd0, vram_waddr, vram_wdata});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (!in_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, in_ready}, 32'd1);
    endtask

    // Returns on the negedge right after acceptance (the strobe cycle for printables).
    task automatic send(input logic [7:0] d, input logic [7:0] a);
        wait_idle(2000, "pre_send_idle");
        in_valid = 1'b1;
        in_data  = d;
        attr     = a;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        attr     = 8'hEE;
    endtask

    task automatic check_fill(input string tag, input int n, input int base, input logic [7:0] a);
        logic [31:0] got;
        check({tag, "_count"}, log_q.size(), n);
        for (int i = 0; i < n; i++) begin
            got = (i < log_q.size()) ? log_q[i] : 32'hFFFF_FFFF;
            check(tag, got, {16'(base + i), a, 8'h20});
        end
    endtask

    task automatic check_cursor(input string tag, input int row, input int col);
        check({tag, "_row"}, {27'd0, cur_row}, row);
        check({tag, "_col"}, {26'd0, cur_col}, col);
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [7:0]  ch;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_we", {31'd0, vram_we}, 0);
        check("rst_waddr", {21'd0, vram_waddr}, 0);
        check("rst_wdata", {16'd0, vram_wdata}, 0);
        check("rst_ready", {31'd0, in_ready}, 0);
        check("rst_busy", {31'd0, busy}, 1);
        check_cursor("rst", 0, 0);

        // Power-up clear with attr 0x07; later attr changes must not leak in
        rst = 1'b0;
        repeat (3) @(negedge clk);
        attr = 8'h55;
        wait_idle(2000, "boot_idle");
        check_fill("boot_clr", 1200, 0, 8'h07);
        check("boot_busy", {31'd0, busy}, 0);
        check_cursor("boot", 0, 0);

        // Single printable at (0,0)
        log_q.delete();
        send(8'h41, 8'h1F);
        check("put_we", {31'd0, vram_we}, 1);
        check("put_waddr", {21'd0, vram_waddr}, 0);
        check("put_wdata", {16'd0, vram_wdata}, 32'h1F41);
        check("put_ready", {31'd0, in_ready}, 0);
        wait_idle(100, "put_idle");
        check_cursor("put", 0, 1);

        // Full line at row 2 wraps into a clear of row 3
        send(8'h0A, 8'h07);
        send(8'h0A, 8'h07);
        wait_idle(100, "lf2_idle");
        check_cursor("lf2", 2, 0);
        log_q.delete();
        for (int i = 0; i < 40; i++) begin
            ch = 8'h41 + 8'(i % 26);
            send(ch, 8'h2E);
        end
        wait_idle(200, "line_idle");
        check("line_count", log_q.size(), 80);
        for (int i = 0; i < 40; i++) begin
            ch = 8'h41 + 8'(i % 26);
            got = (i < log_q.size()) ? log_q[i] : 32'hFFFF_FFFF;
            check("line_char", got, {16'(80 + i), 8'h2E, ch});
        end
        for (int i = 0; i < 40; i++) begin
            got = (40 + i < log_q.size()) ? log_q[40 + i] : 32'hFFFF_FFFF;
            check("line_clr", got, {16'(120 + i), 8'h2E, 8'h20});
        end
        check_cursor("line", 3, 0);

        // LF from the last row wraps to row 0 and clears it
        for (int i = 0; i < 26; i++) send(8'h0A, 8'h07);
        for (int i = 0; i < 5; i++) send(8'h78, 8'h0E);
        wait_idle(100, "r29_idle");
        check_cursor("r29", 29, 5);
        log_q.delete();
        send(8'h0A, 8'h4B);
        wait_idle(100, "wrap_idle");
        check_fill("wrap_clr", 40, 0, 8'h4B);
        check_cursor("wrap", 0, 0);

        // Control bytes: BS at col 0, CR, BS, ignored bytes
        log_q.delete();
        send(8'h08, 8'h11);
        check("bs0_we", {31'd0, vram_we}, 0);
        wait_idle(10, "bs0_idle");
        check_cursor("bs0", 0, 0);
        for (int i = 0; i < 12; i++) send(8'h23, 8'h22);
        wait_idle(10, "c12_idle");
        check_cursor("c12", 0, 12);
        log_q.delete();
        send(8'h0D, 8'h11);
        check("cr_we", {31'd0, vram_we}, 0);
        check("cr_ready", {31'd0, in_ready}, 1);
        check_cursor("cr", 0, 0);
        for (int i = 0; i < 3; i++) send(8'h23, 8'h22);
        wait_idle(10, "c3_idle");
        log_q.delete();
        send(8'h08, 8'h11);
        wait_idle(10, "bs_idle");
        check_cursor("bs", 0, 2);
        send(8'h01, 8'h11);
        send(8'h7F, 8'h11);
        wait_idle(10, "ign_idle");
        check_cursor("ign", 0, 2);
        check("ctrl_nowrite", log_q.size(), 0);
        send(8'h7E, 8'h5A);
        check("tilde_waddr", {21'd0, vram_waddr}, 2);
        check("tilde_wdata", {16'd0, vram_wdata}, 32'h5A7E);
        send(8'h20, 8'h5A);
        check("space_we", {31'd0, vram_we}, 1);
        wait_idle(10, "space_idle");
        check("hold_we", {31'd0, vram_we}, 0);
        check("hold_waddr", {21'd0, vram_waddr}, 3);
        check("hold_wdata", {16'd0, vram_wdata}, 32'h5A20);
        check_cursor("space", 0, 4);

        // Form feed clears the screen and homes the cursor
        log_q.delete();
        send(8'h0C, 8'h30);
        check_cursor("ff_busy", 0, 4);
        wait_idle(2000, "ff_idle");
        check_fill("ff_clr", 1200, 0, 8'h30);
        check_cursor("ff", 0, 0);

        // Reset during the 10th clear-line strobe aborts and restarts a full clear
        send(8'h0A, 8'h44);
        repeat (9) @(negedge clk);
        check("abort_we_pre", {31'd0, vram_we}, 1);
        check("abort_waddr_pre", {21'd0, vram_waddr}, 49);
        rst = 1'b1;
        #1;
        check("abort_we_async", {31'd0, vram_we}, 0);
        log_q.delete();
        @(negedge clk);
        @(negedge clk);
        check("abort_ready", {31'd0, in_ready}, 0);
        check("abort_busy", {31'd0, busy}, 1);
        check("abort_waddr", {21'd0, vram_waddr}, 0);
        check_cursor("abort", 0, 0);
        attr = 8'h61;
        rst = 1'b0;
        wait_idle(2000, "reboot_idle");
        check_fill("reboot_clr", 1200, 0, 8'h61);
        check_cursor("reboot", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
